// File: rtl/cavlc_block_sequencer.sv
// Sequences one CAVLC residual block through coeff_token, level, total_zeros and
// run_before, muxing their barrel-shifter requests. Optional watchdog: CAVLC_WATCHDOG_EN.
module cavlc_block_sequencer #(
  parameter int MAX_COEFF_W    = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   BlockStart,
  input  logic [MAX_COEFF_W-1:0] BlockMaxCoeff,
  output logic                   BlockBusy,
  output logic                   BlockDone,
  output logic                   BlockError,
  output logic                   CtEnable,
  output logic                   LvEnable,
  output logic                   TzEnable,
  output logic                   RbEnable,
  input  logic                   CtDone,
  input  logic                   LvDone,
  input  logic                   TzDone,
  input  logic                   RbDone,
  input  logic [MAX_COEFF_W-1:0] CtTotalCoeff,
  input  logic [1:0]             CtTrailingOnes,
  input  logic [3:0]             TzTotalZeros,
  input  logic [4:0]             CtNumShift,
  input  logic [4:0]             LvNumShift,
  input  logic [4:0]             TzNumShift,
  input  logic [4:0]             RbNumShift,
  input  logic                   CtShiftEn,
  input  logic                   LvShiftEn,
  input  logic                   TzShiftEn,
  input  logic                   RbShiftEn,
  output logic [MAX_COEFF_W-1:0] TotalCoeff,
  output logic [1:0]             TrailingOnes,
  output logic [4:0]             NumShift,
  output logic                   ShiftEn
);

  typedef enum logic [2:0] {
    S_IDLE, S_COEFF, S_LATCH, S_LEVEL, S_TZERO, S_RUN, S_FINISH, S_ERROR
  } state_e;

  state_e                 state_q, state_d;
  logic [MAX_COEFF_W-1:0] maxCoeff_q, maxCoeff_d;
  logic [MAX_COEFF_W-1:0] totalCoeff_q, totalCoeff_d;
  logic [1:0]             trailingOnes_q, trailingOnes_d;
  logic                   wdExpired;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= S_IDLE;
      maxCoeff_q     <= '0;
      totalCoeff_q   <= '0;
      trailingOnes_q <= '0;
    end else begin
      state_q        <= state_d;
      maxCoeff_q     <= maxCoeff_d;
      totalCoeff_q   <= totalCoeff_d;
      trailingOnes_q <= trailingOnes_d;
    end
  end

`ifdef CAVLC_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wdCnt_q, wdCnt_d;
  logic            inStage;

  // Counter holds cycles already spent in the current stage; expiry on the last allowed one.
  assign inStage   = (state_q == S_COEFF) || (state_q == S_LEVEL) ||
                     (state_q == S_TZERO) || (state_q == S_RUN);
  assign wdExpired = (wdCnt_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wdCnt_d = '0;
    if (inStage && (state_d == state_q)) begin
      wdCnt_d = wdCnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wdCnt_q <= '0;
    end else begin
      wdCnt_q <= wdCnt_d;
    end
  end
`else
  assign wdExpired = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    maxCoeff_d     = maxCoeff_q;
    totalCoeff_d   = totalCoeff_q;
    trailingOnes_d = trailingOnes_q;
    BlockDone      = 1'b0;
    BlockError     = 1'b0;
    CtEnable       = 1'b0;
    LvEnable       = 1'b0;
    TzEnable       = 1'b0;
    RbEnable       = 1'b0;
    NumShift       = '0;
    ShiftEn        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (BlockStart) begin
          maxCoeff_d = BlockMaxCoeff;
          state_d    = S_COEFF;
        end
      end
      S_COEFF: begin
        CtEnable = 1'b1;
        NumShift = CtNumShift;
        ShiftEn  = CtShiftEn;
        if (CtDone) begin
          totalCoeff_d   = CtTotalCoeff;
          trailingOnes_d = CtTrailingOnes;
          state_d        = S_LATCH;
        end else if (wdExpired) begin
          state_d = S_ERROR;
        end
      end
      S_LATCH: begin
        if ((MAX_COEFF_W'(trailingOnes_q) > totalCoeff_q) || (totalCoeff_q > maxCoeff_q)) begin
          state_d = S_ERROR;
        end else if (totalCoeff_q == '0) begin
          state_d = S_FINISH;
        end else begin
          state_d = S_LEVEL;
        end
      end
      S_LEVEL: begin
        LvEnable = 1'b1;
        NumShift = LvNumShift;
        ShiftEn  = LvShiftEn;
        if (LvDone) begin
          state_d = (totalCoeff_q == maxCoeff_q) ? S_FINISH : S_TZERO;
        end else if (wdExpired) begin
          state_d = S_ERROR;
        end
      end
      S_TZERO: begin
        TzEnable = 1'b1;
        NumShift = TzNumShift;
        ShiftEn  = TzShiftEn;
        if (TzDone) begin
          state_d = (TzTotalZeros == 4'd0) ? S_FINISH : S_RUN;
        end else if (wdExpired) begin
          state_d = S_ERROR;
        end
      end
      S_RUN: begin
        RbEnable = 1'b1;
        NumShift = RbNumShift;
        ShiftEn  = RbShiftEn;
        if (RbDone) begin
          state_d = S_FINISH;
        end else if (wdExpired) begin
          state_d = S_ERROR;
        end
      end
      S_FINISH: begin
        BlockDone = 1'b1;
        state_d   = S_IDLE;
      end
      S_ERROR: begin
        BlockError = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign BlockBusy    = (state_q != S_IDLE);
  assign TotalCoeff   = totalCoeff_q;
  assign TrailingOnes = trailingOnes_q;

endmodule

// File: doc/cavlc_block_sequencer.md
# cavlc_block_sequencer

Sequences one CAVLC residual block through the four decode stages: coeff_token, level, total_zeros and run_before. It shares the single bitstream barrel shifter between those stages by muxing their shift requests. It latches the coeff_token results and presents them to the level stage. It sits between the slice-level residual controller and the per-stage decoders.

## Interface
Parameters:
- MAX_COEFF_W, 5: width of coefficient-count fields.
- TIMEOUT_CYCLES, 64: watchdog limit per stage, in cycles. Used only with CAVLC_WATCHDOG_EN.

Ports:
- Clk  in  1  clock.
- Reset  in  1  synchronous, active-high reset.
- BlockStart  in  1  request to decode one block. Sampled only in IDLE.
- BlockMaxCoeff  in  5  maxNumCoeff for the block (16, 15 or 4). Latched with BlockStart.
- BlockBusy  out  1  high in every state except IDLE.
- BlockDone  out  1  one-cycle pulse at block completion.
- BlockError  out  1  one-cycle pulse on abort.
- CtEnable, LvEnable, TzEnable, RbEnable  out  1 each  stage enables.
- CtDone, LvDone, TzDone, RbDone  in  1 each  stage done flags.
- CtTotalCoeff  in  5, CtTrailingOnes  in  2  coeff_token results. Valid when CtDone is high.
- TzTotalZeros  in  4  total_zeros result. Valid when TzDone is high.
- CtNumShift, LvNumShift, TzNumShift, RbNumShift  in  5 each  per-stage shift amounts.
- CtShiftEn, LvShiftEn, TzShiftEn, RbShiftEn  in  1 each  per-stage shift enables.
- TotalCoeff  out  5, TrailingOnes  out  2  latched results, fed to the level stage.
- NumShift  out  5, ShiftEn  out  1  muxed request to the barrel shifter.

## Operation
States: IDLE, COEFF, LATCH, LEVEL, TZERO, RUN, FINISH, ERROR.
- **IDLE:**
  - BlockStart=1 → latch BlockMaxCoeff, go to COEFF.
  - BlockStart is ignored in all other states.
- **COEFF:**
  - CtEnable=1.
  - On CtDone, register CtTotalCoeff and CtTrailingOnes into TotalCoeff and TrailingOnes, then go to LATCH.
- **LATCH:** one cycle, all enables low. Check the latched values:
  - TrailingOnes>TotalCoeff, or TotalCoeff>MaxCoeff → ERROR.
  - TotalCoeff==0 → FINISH.
  - Otherwise → LEVEL.
- **LEVEL:**
  - LvEnable=1, held continuously until LvDone. The level stage clears its internal counters when its enable drops.
  - On LvDone: TotalCoeff==MaxCoeff → FINISH; otherwise → TZERO.
- **TZERO:**
  - TzEnable=1.
  - On TzDone: TzTotalZeros==0 → FINISH; otherwise → RUN.
- **RUN:**
  - RbEnable=1.
  - On RbDone → FINISH.
- **FINISH:** BlockDone=1 for one cycle, then → IDLE.
- **ERROR:** BlockError=1 for one cycle, then → IDLE.

Shift mux:
- Combinational, selected by the current state: COEFF→Ct, LEVEL→Lv, TZERO→Tz, RUN→Rb.
- In all other states NumShift=0 and ShiftEn=0.
- Shift inputs from inactive stages are ignored.

General rules:
- At most one stage enable is high in any cycle.
- Each enable drops for at least one cycle between stages.
- TotalCoeff and TrailingOnes hold from LATCH until the next COEFF completes.

## Timing
- Reset values: state IDLE; every output 0; TotalCoeff=0; TrailingOnes=0.
- Stage enables, BlockBusy, BlockDone and BlockError are decoded from the state register, so they change one cycle after the causing input.
- BlockStart in cycle N → CtEnable=1 in cycle N+1.
- Done high in cycle N → that stage's enable is low in cycle N+1.
  - The next stage's enable goes high in N+1, except after COEFF, where LATCH adds one cycle.
- The shift request presented in the same cycle as Done is still forwarded.
- Minimum block, TotalCoeff==0 with CtDone in the first COEFF cycle: BlockStart at N → BlockDone at N+3.
- Back-to-back blocks: the earliest accepted BlockStart is in the cycle after BlockDone, i.e. the IDLE cycle.
- Reset asserted mid-block: in the next cycle the state is IDLE and all enables are 0. No BlockDone or BlockError pulse.
- A Done input from an inactive stage is ignored.

## Configuration
- **CAVLC_WATCHDOG_EN defined:**
  - A counter of width ceil(log2(TIMEOUT_CYCLES+1)) clears on every state change.
  - It counts each cycle spent in COEFF, LEVEL, TZERO or RUN.
  - Reaching TIMEOUT_CYCLES without the active Done → ERROR. The stage enable drops in the following cycle.
- **CAVLC_WATCHDOG_EN undefined:**
  - No counter is built.
  - The stage states wait indefinitely.
  - ERROR is reachable only from the LATCH consistency checks.

## Test plan
- Reset, then idle 10 cycles → all outputs 0, BlockBusy=0.
- BlockStart, MaxCoeff=16; CtDone with TotalCoeff=0 → LvEnable never asserted; BlockDone exactly 3 cycles after BlockStart.
- Full path:
  - Stimulus: MaxCoeff=16, TotalCoeff=5, TrailingOnes=2, TotalZeros=3.
  - Required: enables Ct, Lv, Tz, Rb in sequence with no overlap; TotalCoeff=5 and TrailingOnes=2 stable throughout LEVEL; NumShift equals the active stage's value every cycle; one BlockDone.
- Skip paths:
  - TotalCoeff=16, MaxCoeff=16 → FINISH straight after LEVEL; no Tz or Rb enable.
  - TotalZeros=0 → no Rb enable.
- Errors:
  - TrailingOnes=3, TotalCoeff=2 → BlockError pulse; no LvEnable.
  - With CAVLC_WATCHDOG_EN and TIMEOUT_CYCLES=64, LvDone held low → BlockError in the 65th LEVEL cycle; next block decodes normally.
- Reset asserted during RUN → next cycle IDLE with all enables 0; BlockStart issued two cycles later decodes correctly; BlockStart asserted while busy has no effect.
